// File: rtl/memory_stage_ctrl_pkg.sv
// Shared CPU types and the memory-stage controller state encoding.
package memory_stage_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALT   = 2'd3
    } memstate_t;

endpackage

// File: rtl/memory_stage_ctrl.sv
// MEM-stage controller: issues dcache requests, holds them until dhit, captures
// the load word, drives the memory latch enable/stall and sequences halt.
module memory_stage_ctrl
    import memory_stage_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic [31:0]      exmem_addr,
    input  logic [31:0]      exmem_store,
    input  logic             exmem_halt,
    input  logic             advance_in,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic [31:0]      dload,
    output logic             mem_en,
    output logic             mem_stall,
    output logic             halt_out,
    output logic [CNT_W-1:0] dacc_count
);

    memstate_t        r_state;
    memstate_t        w_next;
    word_t            r_dload;
    logic [CNT_W-1:0] r_count;
    logic             r_halt;
    logic             w_req;
    logic             w_capture;
    logic             w_set_halt;

    assign w_req     = exmem_dREN | exmem_dWEN;
    assign dmemaddr  = exmem_addr;
    assign dmemstore = exmem_store;

    // Next state and combinational outputs; write wins over read when both set.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_set_halt = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        mem_en     = 1'b0;
        mem_stall  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    dmemWEN   = exmem_dWEN;
                    dmemREN   = exmem_dREN & ~exmem_dWEN;
                    mem_stall = 1'b1;
                    if (dhit) begin
                        w_capture = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next    = ACCESS;
                    end
                end else begin
                    mem_en = advance_in;
                    if (exmem_halt && advance_in) begin
                        w_set_halt = 1'b1;
                        w_next     = HALT;
                    end
                end
            end
            ACCESS: begin
                dmemWEN   = exmem_dWEN;
                dmemREN   = exmem_dREN & ~exmem_dWEN;
                mem_stall = 1'b1;
                if (dhit) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                mem_en    = advance_in;
                mem_stall = ~advance_in;
                if (advance_in) begin
                    if (exmem_halt) begin
                        w_set_halt = 1'b1;
                        w_next     = HALT;
                    end else begin
                        w_next     = IDLE;
                    end
                end
            end
            HALT: begin
                mem_stall = 1'b1;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, captured load word, sticky halt and wrapping access counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_dload <= '0;
            r_count <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_dload <= dmemload;
                r_count <= r_count + CNT_W'(1);
            end
            if (w_set_halt) begin
                r_halt <= 1'b1;
            end
        end
    end

    assign dload      = r_dload;
    assign dacc_count = r_count;
    assign halt_out   = r_halt;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Directed bench for memory_stage_ctrl with hand-computed expectations (CNT_W=4).
module tb_memory_stage_ctrl;

    logic        CLK;
    logic        nRST;
    logic        exmem_dREN;
    logic        exmem_dWEN;
    logic [31:0] exmem_addr;
    logic [31:0] exmem_store;
    logic        exmem_halt;
    logic        advance_in;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dload;
    logic        mem_en;
    logic        mem_stall;
    logic        halt_out;
    logic [3:0]  dacc_count;

    int n_checks;
    int n_fail;

    memory_stage_ctrl #(.CNT_W(4)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .exmem_dREN  (exmem_dREN),
        .exmem_dWEN  (exmem_dWEN),
        .exmem_addr  (exmem_addr),
        .exmem_store (exmem_store),
        .exmem_halt  (exmem_halt),
        .advance_in  (advance_in),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .dload       (dload),
        .mem_en      (mem_en),
        .mem_stall   (mem_stall),
        .halt_out    (halt_out),
        .dacc_count  (dacc_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, then let combinational outputs settle.
    task automatic set_in(input logic ren, input logic wen, input logic hlt,
                          input logic adv, input logic hit);
        @(negedge CLK);
        exmem_dREN = ren;
        exmem_dWEN = wen;
        exmem_halt = hlt;
        advance_in = adv;
        dhit       = hit;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        nRST        = 1'b0;
        exmem_dREN  = 1'b0;
        exmem_dWEN  = 1'b0;
        exmem_addr  = 32'h0;
        exmem_store = 32'h0;
        exmem_halt  = 1'b0;
        advance_in  = 1'b0;
        dhit        = 1'b0;
        dmemload    = 32'h0;
        #12;
        check_eq("rst_dload", dload, 32'h0);
        check_eq("rst_count", 32'(dacc_count), 32'h0);
        check_eq("rst_halt", 32'(halt_out), 32'h0);
        check_eq("rst_stall", 32'(mem_stall), 32'h0);
        check_eq("rst_ren", 32'(dmemREN), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Load hitting in its issue cycle
        exmem_addr = 32'h0000_0100;
        dmemload   = 32'hDEAD_BEEF;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ld_ren", 32'(dmemREN), 32'h1);
        check_eq("ld_wen", 32'(dmemWEN), 32'h0);
        check_eq("ld_stall", 32'(mem_stall), 32'h1);
        check_eq("ld_en", 32'(mem_en), 32'h0);
        check_eq("ld_addr", dmemaddr, 32'h0000_0100);
        tick();
        check_eq("ld_dload", dload, 32'hDEAD_BEEF);
        check_eq("ld_count", 32'(dacc_count), 32'h1);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ld_done_en", 32'(mem_en), 32'h1);
        check_eq("ld_done_stall", 32'(mem_stall), 32'h0);
        check_eq("ld_done_ren", 32'(dmemREN), 32'h0);
        tick();

        // Store with dhit on the fourth request cycle
        exmem_store = 32'h1234_5678;
        exmem_addr  = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0);
            check_eq("st_wen", 32'(dmemWEN), 32'h1);
            check_eq("st_stall", 32'(mem_stall), 32'h1);
            check_eq("st_en", 32'(mem_en), 32'h0);
            check_eq("st_count_hold", 32'(dacc_count), 32'h1);
            tick();
        end
        check_eq("st_data", dmemstore, 32'h1234_5678);
        check_eq("st_count", 32'(dacc_count), 32'h2);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("st_done_wen", 32'(dmemWEN), 32'h0);
        check_eq("st_done_en", 32'(mem_en), 32'h1);
        tick();
        check_eq("st_count_once", 32'(dacc_count), 32'h2);

        // Load completes, then the latch is held back for two cycles
        dmemload = 32'hCAFE_F00D;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("hold_dload", dload, 32'hCAFE_F00D);
        check_eq("hold_count", 32'(dacc_count), 32'h3);
        dmemload = 32'h1111_1111;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("hold_ren", 32'(dmemREN), 32'h0);
            check_eq("hold_en", 32'(mem_en), 32'h0);
            check_eq("hold_stall", 32'(mem_stall), 32'h1);
            tick();
            check_eq("hold_dload_kept", dload, 32'hCAFE_F00D);
            check_eq("hold_count_kept", 32'(dacc_count), 32'h3);
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("hold_release_en", 32'(mem_en), 32'h1);
        tick();

        // Illegal read+write: write wins
        dmemload = 32'hCAFE_F00D;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("rw_wen", 32'(dmemWEN), 32'h1);
        check_eq("rw_ren", 32'(dmemREN), 32'h0);
        tick();
        check_eq("rw_count", 32'(dacc_count), 32'h4);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // Non-memory instruction: latch follows advance_in, stray dhit ignored
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("nm_en_hi", 32'(mem_en), 32'h1);
        check_eq("nm_stall", 32'(mem_stall), 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("nm_en_lo", 32'(mem_en), 32'h0);
        tick();
        check_eq("nm_count", 32'(dacc_count), 32'h4);
        check_eq("nm_dload", dload, 32'hCAFE_F00D);

        // Halt sequencing
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("ht_en", 32'(mem_en), 32'h1);
        check_eq("ht_pre", 32'(halt_out), 32'h0);
        tick();
        check_eq("ht_out", 32'(halt_out), 32'h1);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("ht_ren", 32'(dmemREN), 32'h0);
        check_eq("ht_stall", 32'(mem_stall), 32'h1);
        check_eq("ht_en_off", 32'(mem_en), 32'h0);
        tick();
        check_eq("ht_sticky", 32'(halt_out), 32'h1);
        check_eq("ht_count", 32'(dacc_count), 32'h4);
        nRST = 1'b0;
        #1;
        check_eq("ht_rst_halt", 32'(halt_out), 32'h0);
        check_eq("ht_rst_ren", 32'(dmemREN), 32'h1);
        check_eq("ht_rst_count", 32'(dacc_count), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Counter wrap: 15 hits to all-ones, one more to zero
        for (int i = 0; i < 16; i++) begin
            dmemload = 32'hA5A5_0000 + 32'(i);
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (i == 14) check_eq("wrap_full", 32'(dacc_count), 32'hF);
        end
        check_eq("wrap_zero", 32'(dacc_count), 32'h0);
        check_eq("wrap_dload", dload, 32'hA5A5_000F);

        // Asynchronous reset while a request is outstanding
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("acc_ren", 32'(dmemREN), 32'h1);
        check_eq("acc_stall", 32'(mem_stall), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("acc_rst_dload", dload, 32'h0);
        check_eq("acc_rst_count", 32'(dacc_count), 32'h0);
        exmem_dREN = 1'b0;
        advance_in = 1'b1;
        #1;
        check_eq("acc_rst_ren", 32'(dmemREN), 32'h0);
        check_eq("acc_rst_idle_en", 32'(mem_en), 32'h1);
        check_eq("acc_rst_idle_stall", 32'(mem_stall), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
